// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Initiator for a combinational 4-bit ALU. Commands arrive on a valid/ready
//   stream and are queued in a small FIFO. An IDLE/EXEC/RESP FSM drives one
//   command at a time into the ALU, captures its result and flags, and returns
//   a tagged response on a valid/ready stream with backpressure. An optional
//   4-bit accumulator can replace operand A and capture results.
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (cmd_ready = FIFO not full)
//   cmd_op/a/b/acc_sel/acc_wr/tag    command fields
//   acc_clr                          clear accumulator (wins over an acc write)
//   alu_a/alu_b/alu_op               registered drive into the ALU
//   alu_result/alu_carr/alu_zero     ALU outputs
//   rsp_valid/rsp_ready              response handshake
//   rsp_result/carr/zero/tag         captured response fields
//   acc                              accumulator value
//   busy                             FSM not idle or FIFO non-empty
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_acc_sel,
  input  logic             cmd_acc_wr,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             acc_clr,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_carr,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_carr,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [3:0]       acc,
  output logic             busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TAG_W + 13;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       state;
  logic             full;
  logic             push;
  logic             pop;
  logic [2:0]       head_op;
  logic [3:0]       head_a;
  logic [3:0]       head_b;
  logic             head_sel;
  logic             head_wr;
  logic [TAG_W-1:0] head_tag;
  logic             cur_wr;
  logic [TAG_W-1:0] cur_tag;

  // Ready depends only on the registered count, so a same-cycle pop never
  // reopens a full FIFO.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = (state == IDLE) && (count != '0);

  assign {head_op, head_a, head_b, head_sel, head_wr, head_tag} = mem[rd_ptr];

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || (count != '0);

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_acc_sel, cmd_acc_wr, cmd_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      cur_wr     <= 1'b0;
      cur_tag    <= '0;
      rsp_result <= '0;
      rsp_carr   <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
      acc        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: begin
          if (pop) begin
            // acc is the registered value, i.e. before any coincident clear.
            alu_a   <= head_sel ? acc : head_a;
            alu_b   <= head_b;
            alu_op  <= head_op;
            cur_wr  <= head_wr;
            cur_tag <= head_tag;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_carr   <= alu_carr;
          rsp_zero   <= alu_zero;
          rsp_tag    <= cur_tag;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (acc_clr) begin
        acc <= '0;
      end else if ((state == EXEC) && cur_wr) begin
        acc <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_acc_sel;
  logic       cmd_acc_wr;
  logic [1:0] cmd_tag;
  logic       acc_clr;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carr;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carr;
  logic       rsp_zero;
  logic [1:0] rsp_tag;
  logic [3:0] acc;
  logic       busy;

  alu_cmd_sequencer #(.FIFO_DEPTH(4), .TAG_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_acc_sel(cmd_acc_sel), .cmd_acc_wr(cmd_acc_wr), .cmd_tag(cmd_tag),
    .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carr(alu_carr), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carr(rsp_carr), .rsp_zero(rsp_zero),
    .rsp_tag(rsp_tag), .acc(acc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour in plain integer arithmetic: {carry, zero, result}
  function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    int r;
    logic c;
    c = 1'b0;
    case (op)
      3'd0: begin r = int'(a) + int'(b); c = (r > 15); end
      3'd1: begin r = int'(a) - int'(b); c = (a < b); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 15 - int'(a);
      3'd6: begin r = int'(a) * 2; c = (a >= 8); end
      default: begin r = int'(a) / 2; c = (a % 2) == 1; end
    endcase
    r = r & 15;
    return {c, (r == 0), 4'(r)};
  endfunction

  always_comb {alu_carr, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic       wr;
    logic [1:0] tag;
  } cmd_t;

  cmd_t       q[$];
  logic [3:0] macc;
  logic       chk_acc;
  int         n_rsp;
  int         tests;
  int         fails;
  logic [3:0] last_res;
  logic       last_carr;
  logic       last_zero;
  logic [1:0] last_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock edge; handshakes are judged on the values held before the edge.
  task automatic cyc();
    logic       push;
    logic       pop;
    cmd_t       c;
    cmd_t       h;
    logic [3:0] av;
    logic [5:0] e;
    push = cmd_valid && cmd_ready && !rst;
    pop  = rsp_valid && rsp_ready && !rst;
    c = '{cmd_op, cmd_a, cmd_b, cmd_acc_sel, cmd_acc_wr, cmd_tag};
    if (pop) begin
      chk("rsp_has_cmd", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        h  = q.pop_front();
        av = h.sel ? macc : h.a;
        e  = alu_f(h.op, av, h.b);
        chk("rsp_result", rsp_result, e[3:0]);
        chk("rsp_carr", rsp_carr, e[5]);
        chk("rsp_zero", rsp_zero, e[4]);
        chk("rsp_tag", rsp_tag, h.tag);
        if (h.wr) macc = e[3:0];
        if (chk_acc) chk("acc", acc, macc);
      end
      last_res  = rsp_result;
      last_carr = rsp_carr;
      last_zero = rsp_zero;
      last_tag  = rsp_tag;
      n_rsp++;
    end
    @(posedge clk);
    #1;
    if (push) q.push_back(c);
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic sel, input logic wr, input logic [1:0] tag);
    logic done;
    cmd_op = op; cmd_a = a; cmd_b = b;
    cmd_acc_sel = sel; cmd_acc_wr = wr; cmd_tag = tag;
    cmd_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      done = cmd_ready;
      cyc();
    end
    cmd_valid = 1'b0;
    chk("accept_in_time", done, 1);
  endtask

  task automatic wait_rsp();
    int target;
    target = n_rsp + 1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && n_rsp < target; i++) cyc();
    rsp_ready = 1'b0;
    chk("rsp_in_time", n_rsp, target);
  endtask

  initial begin
    int accepted;
    int base;
    tests = 0; fails = 0; n_rsp = 0; macc = '0; chk_acc = 1'b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_acc_sel = 1'b0; cmd_acc_wr = 1'b0; cmd_tag = '0; acc_clr = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_tag", rsp_tag, 0);

    // Test 1: add 9+8, latency from the edge preceding the push
    send(3'd0, 4'd9, 4'd8, 1'b0, 1'b0, 2'd1);
    chk("t1_valid_k1", rsp_valid, 0);
    cyc();
    chk("t1_valid_k2", rsp_valid, 0);
    chk("t1_busy", busy, 1);
    chk("t1_alu_a", alu_a, 4'd9);
    chk("t1_alu_b", alu_b, 4'd8);
    chk("t1_alu_op", alu_op, 3'd0);
    cyc();
    chk("t1_valid_k3", rsp_valid, 1);
    chk("t1_result", rsp_result, 4'd1);
    chk("t1_carr", rsp_carr, 1);
    chk("t1_zero", rsp_zero, 0);
    chk("t1_tag", rsp_tag, 2'd1);
    cyc();
    chk("t1_held", rsp_result, 4'd1);
    wait_rsp();
    chk("t1_idle", rsp_valid, 0);

    // Test 2: sub borrow and zero flag
    send(3'd1, 4'd3, 4'd5, 1'b0, 1'b0, 2'd2);
    wait_rsp();
    chk("t2_sub_res", last_res, 4'hE);
    chk("t2_sub_carr", last_carr, 1);
    send(3'd2, 4'hA, 4'h5, 1'b0, 1'b0, 2'd3);
    wait_rsp();
    chk("t2_and_res", last_res, 4'h0);
    chk("t2_and_zero", last_zero, 1);

    // Test 3: fill under backpressure, then drain in order
    accepted = 0;
    base = n_rsp;
    cmd_acc_sel = 1'b0; cmd_acc_wr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_a     = 4'(accepted);
      cmd_b     = 4'($urandom);
      cmd_tag   = 2'(accepted);
      if (cmd_ready) accepted++;
      cyc();
    end
    cmd_valid = 1'b0;
    chk("t3_accepted", accepted, 5);
    chk("t3_cmd_ready", cmd_ready, 0);
    chk("t3_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) cyc();
    rsp_ready = 1'b0;
    chk("t3_drained", n_rsp - base, 5);
    chk("t3_queue_empty", q.size(), 0);

    // Test 4: accumulator chain
    acc_clr = 1'b1;
    cyc();
    acc_clr = 1'b0;
    macc = '0;
    chk("t4_clr", acc, 0);
    send(3'd0, 4'd3, 4'd0, 1'b0, 1'b1, 2'd0);
    wait_rsp();
    chk("t4_acc3", acc, 4'd3);
    send(3'd0, 4'd0, 4'd4, 1'b1, 1'b1, 2'd1);
    wait_rsp();
    chk("t4_acc7", acc, 4'd7);
    send(3'd6, 4'd0, 4'd0, 1'b1, 1'b1, 2'd2);
    wait_rsp();
    chk("t4_accE", acc, 4'hE);
    chk("t4_carr", last_carr, 0);

    // Test 5: clear coincident with the EXEC accumulator write
    send(3'd0, 4'd5, 4'd0, 1'b0, 1'b1, 2'd3);
    cyc();
    acc_clr = 1'b1;
    cyc();
    acc_clr = 1'b0;
    chk("t5_clr_wins", acc, 0);
    chk("t5_rsp", rsp_result, 4'd5);
    wait_rsp();
    macc = '0;
    send(3'd7, 4'd9, 4'($urandom), 1'b1, 1'b0, 2'd0);
    wait_rsp();
    chk("t5_shr_res", last_res, 0);
    chk("t5_shr_zero", last_zero, 1);

    // Test 6: reset while in RESP with two commands queued
    send(3'd0, 4'd6, 4'd1, 1'b0, 1'b1, 2'd1);
    send(3'd3, 4'd1, 4'd2, 1'b0, 1'b0, 2'd2);
    send(3'd4, 4'd3, 4'd5, 1'b0, 1'b0, 2'd3);
    for (int i = 0; i < 10 && !rsp_valid; i++) cyc();
    chk("t6_in_resp", rsp_valid, 1);
    chk("t6_acc7", acc, 4'd7);
    chk("t6_full_q", q.size(), 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_acc", acc, 0);
    q.delete();
    macc = '0;

    // Random traffic against the reference model
    chk_acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cmd_valid   = 1'($urandom);
      cmd_op      = 3'($urandom);
      cmd_a       = 4'($urandom);
      cmd_b       = 4'($urandom);
      cmd_acc_sel = 1'($urandom);
      cmd_acc_wr  = 1'($urandom);
      cmd_tag     = 2'($urandom);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      cyc();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && (q.size() != 0 || rsp_valid); i++) cyc();
    chk("rand_queue_empty", q.size(), 0);
    chk("rand_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
